// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter and its array.
// The response tag records who owns the in-flight access and how to shape its reply.
package imem_pkg;

  localparam int DEFAULT_DEPTH     = 32;
  localparam int DEFAULT_MAX_BURST = 8;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    LDR
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_LDR
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   err;
    logic   isWrite;
  } rsp_tag_t;

  // Word aligned and inside the array; a byte address maps to word addr[31:2].
  function automatic logic addrInRange(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch and loader request/response signals shared by the arbiter and its requesters.
// master is the requester side, slave is the arbiter side.
interface imem_arbiter_if;

  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;

  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic        l_err;

  logic        cpu_stall;

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err, cpu_stall
  );

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err, cpu_stall
  );

endinterface

// File: rtl/imem_array.sv
// Single-port instruction memory with a registered read; a write also updates the read
// register so the written word is what the port presents next cycle.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= we_i ? wdata_i : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single memory port between CPU fetch and the program loader, caps loader
// bursts while fetch waits, and steers each registered read back to the requester that issued it.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_arbiter_if.slave    bus,
  output logic             m_en,
  output logic             m_we,
  output logic [IDX_W-1:0] m_idx,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_state_t         state_q, state_d;
  logic [BURST_W-1:0] burstCnt_q, burstCnt_d;
  rsp_tag_t           tag_q, tag_d;

  logic fGnt;
  logic lGnt;
  logic fAddrOk;
  logic lAddrOk;
  logic burstFull;
  logic fRvalid;
  logic lRvalid;

  assign fAddrOk   = addrInRange(bus.f_addr, DEPTH);
  assign lAddrOk   = addrInRange(bus.l_addr, DEPTH);
  assign burstFull = (burstCnt_q == BURST_W'(MAX_BURST));

  always_comb begin
    fGnt       = 1'b0;
    lGnt       = 1'b0;
    state_d    = IDLE;
    burstCnt_d = burstCnt_q;
    tag_d      = '0;

    if (rst_n) begin
      case (state_q)
        CPU: begin
          if (bus.f_req)      fGnt = 1'b1;
          else if (bus.l_req) lGnt = 1'b1;
        end
        LDR: begin
          // A full burst hands exactly one slot to a waiting fetch.
          if (bus.l_req && !(burstFull && bus.f_req)) lGnt = 1'b1;
          else if (bus.f_req)                          fGnt = 1'b1;
        end
        default: begin
          if (bus.l_req)      lGnt = 1'b1;
          else if (bus.f_req) fGnt = 1'b1;
        end
      endcase
    end

    if (fGnt)      state_d = CPU;
    else if (lGnt) state_d = LDR;

    // Only loader grants taken while fetch is waiting count toward the cap.
    if (!bus.f_req || fGnt) begin
      burstCnt_d = '0;
    end else if (lGnt && !burstFull) begin
      burstCnt_d = burstCnt_q + 1'b1;
    end

    if (fGnt) begin
      tag_d.valid = 1'b1;
      tag_d.owner = OWN_CPU;
      tag_d.err   = !fAddrOk;
    end else if (lGnt) begin
      tag_d.valid   = 1'b1;
      tag_d.owner   = OWN_LDR;
      tag_d.err     = !lAddrOk;
      tag_d.isWrite = bus.l_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      burstCnt_q <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      burstCnt_q <= burstCnt_d;
      tag_q      <= tag_d;
    end
  end

  // Invalid accesses are still granted but never touch the array.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_idx   = '0;
    m_wdata = '0;
    if (fGnt && fAddrOk) begin
      m_en  = 1'b1;
      m_idx = bus.f_addr[IDX_W+1:2];
    end else if (lGnt && lAddrOk) begin
      m_en  = 1'b1;
      m_we  = bus.l_we;
      m_idx = bus.l_addr[IDX_W+1:2];
      if (bus.l_we) m_wdata = bus.l_wdata;
    end
  end

  assign fRvalid = tag_q.valid && (tag_q.owner == OWN_CPU);
  assign lRvalid = tag_q.valid && (tag_q.owner == OWN_LDR);

  assign bus.f_gnt     = fGnt;
  assign bus.l_gnt     = lGnt;
  assign bus.cpu_stall = bus.f_req && !fGnt && rst_n;

  assign bus.f_rvalid = fRvalid;
  assign bus.f_err    = fRvalid && tag_q.err;
  assign bus.f_rdata  = !fRvalid    ? 32'h0 :
                        tag_q.err   ? NOP_INSTR : m_rdata;

  assign bus.l_rvalid = lRvalid;
  assign bus.l_err    = lRvalid && tag_q.err;
  assign bus.l_rdata  = (lRvalid && !tag_q.err && !tag_q.isWrite) ? m_rdata : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter plus imem_array: a transaction-level reference model
// predicts grants and queues expected responses; a monitor pops them when rvalid appears.
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int DEPTH     = DEFAULT_DEPTH;
  localparam int MAX_BURST = DEFAULT_MAX_BURST;
  localparam int IDX_W     = $clog2(DEPTH);

  localparam int WHO_NONE   = 0;
  localparam int WHO_FETCH  = 1;
  localparam int WHO_LOADER = 2;

  typedef struct {
    int          due;
    logic        isLdr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             m_en;
  logic             m_we;
  logic [IDX_W-1:0] m_idx;
  logic [31:0]      m_wdata;
  logic [31:0]      m_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t        sbq[$];
  logic [31:0] refMem [DEPTH];
  int          lastWho  = WHO_NONE;
  int          burstCnt = 0;

  imem_arbiter_if bus();

  imem_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_idx   (m_idx),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  imem_array #(.DEPTH(DEPTH)) mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (m_en),
    .we_i    (m_we),
    .idx_i   (m_idx),
    .wdata_i (m_wdata),
    .rdata_o (m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic checkAllZero();
    checkOutput("zero_f_rvalid", 32'(bus.f_rvalid), 32'h0);
    checkOutput("zero_f_rdata",  bus.f_rdata,       32'h0);
    checkOutput("zero_f_err",    32'(bus.f_err),    32'h0);
    checkOutput("zero_l_rvalid", 32'(bus.l_rvalid), 32'h0);
    checkOutput("zero_l_rdata",  bus.l_rdata,       32'h0);
    checkOutput("zero_l_err",    32'(bus.l_err),    32'h0);
  endtask

  task automatic driveIdle();
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
  endtask

  // One cycle: drive, predict the owner from the last owner and burst count, compare, update.
  task automatic applyStimulus(input logic fr, input logic [31:0] fa,
                               input logic lr, input logic lw,
                               input logic [31:0] la, input logic [31:0] lwd,
                               output logic fg, output logic lg);
    logic        fv, lv, expEn, expWe;
    logic [31:0] expIdx, expWdata;
    exp_t        e;
    @(negedge clk);
    bus.f_req   = fr;
    bus.f_addr  = fa;
    bus.l_req   = lr;
    bus.l_we    = lw;
    bus.l_addr  = la;
    bus.l_wdata = lwd;
    #2;
    fv = (fa % 4 == 0) && ((fa / 4) < DEPTH);
    lv = (la % 4 == 0) && ((la / 4) < DEPTH);
    fg = 1'b0;
    lg = 1'b0;
    if (rst_n) begin
      if (fr && lr) begin
        if (lastWho == WHO_FETCH)                                 fg = 1'b1;
        else if (lastWho == WHO_LOADER && burstCnt >= MAX_BURST)  fg = 1'b1;
        else                                                      lg = 1'b1;
      end else begin
        fg = fr;
        lg = lr;
      end
    end
    expEn    = (fg && fv) || (lg && lv);
    expWe    = lg && lv && lw;
    expIdx   = !expEn ? 32'h0 : (fg ? (fa / 4) : (la / 4));
    expWdata = expWe ? lwd : 32'h0;

    checkOutput("f_gnt",     32'(bus.f_gnt),     32'(fg));
    checkOutput("l_gnt",     32'(bus.l_gnt),     32'(lg));
    checkOutput("cpu_stall", 32'(bus.cpu_stall), 32'(rst_n && fr && !fg));
    checkOutput("m_en",      32'(m_en),          32'(expEn));
    checkOutput("m_we",      32'(m_we),          32'(expWe));
    checkOutput("m_idx",     32'(m_idx),         expIdx);
    checkOutput("m_wdata",   m_wdata,            expWdata);

    if (!rst_n) begin
      lastWho  = WHO_NONE;
      burstCnt = 0;
    end else begin
      e.due = cyc + 1;
      if (fg) begin
        e.isLdr = 1'b0;
        e.err   = !fv;
        e.data  = NOP_INSTR;
        if (fv) e.data = refMem[fa / 4];
        sbq.push_back(e);
        lastWho = WHO_FETCH;
      end else if (lg) begin
        e.isLdr = 1'b1;
        e.err   = !lv;
        e.data  = 32'h0;
        if (lv && !lw) e.data = refMem[la / 4];
        if (lv && lw)  refMem[la / 4] = lwd;
        sbq.push_back(e);
        lastWho = WHO_LOADER;
      end else begin
        lastWho = WHO_NONE;
      end
      if (!fr || fg)                      burstCnt = 0;
      else if (lg && burstCnt < MAX_BURST) burstCnt++;
    end
  endtask

  task automatic releaseReset();
    @(negedge clk);
    driveIdle();
    rst_n = 1'b1;
    #2;
    checkAllZero();
  endtask

  function automatic logic [31:0] randAddr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, DEPTH - 1)) << 2;
    if (r < 9) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    return 32'($urandom_range(DEPTH, 1000)) << 2;
  endfunction

  // Monitor: every response must match the oldest queued prediction and arrive on time.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!bus.f_rvalid) checkOutput("f_rdata_idle", bus.f_rdata, 32'h0);
    if (!bus.l_rvalid) checkOutput("l_rdata_idle", bus.l_rdata, 32'h0);
    if (bus.f_rvalid === 1'b1 || bus.l_rvalid === 1'b1) begin
      checkOutput("one_rvalid", 32'(bus.f_rvalid && bus.l_rvalid), 32'h0);
      if (sbq.size() == 0) begin
        checkOutput("unexpected_rvalid", 32'h1, 32'h0);
      end else begin
        e = sbq.pop_front();
        checkOutput("rsp_cycle", 32'(cyc), 32'(e.due));
        checkOutput("rsp_port",  32'(bus.l_rvalid), 32'(e.isLdr));
        if (e.isLdr) begin
          checkOutput("l_rdata", bus.l_rdata, e.data);
          checkOutput("l_err",   32'(bus.l_err), 32'(e.err));
        end else begin
          checkOutput("f_rdata", bus.f_rdata, e.data);
          checkOutput("f_err",   32'(bus.f_err), 32'(e.err));
        end
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      checkOutput("missing_rvalid", 32'h0, 32'h1);
      void'(sbq.pop_front());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        fg, lg, fPend, lPend, lw, firstL;
    logic [31:0] fa, la, lwd;
    int          lc, fSlot;

    driveIdle();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;

    // Requests asserted during reset must be ignored entirely.
    repeat (2) begin
      applyStimulus(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 32'h1234_5678, fg, lg);
      checkAllZero();
    end
    releaseReset();

    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        0:       lwd = 32'h00A0_0093;
        1:       lwd = 32'h0140_0113;
        2:       lwd = 32'h0000_0193;
        default: lwd = $urandom;
      endcase
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'(i) << 2, lwd, fg, lg);
    end

    $display("[TB] fetch-only sequence");
    applyStimulus(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    applyStimulus(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    applyStimulus(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);

    $display("[TB] loader write then fetch");
    applyStimulus(1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, fg, lg);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,         fg, lg);

    $display("[TB] invalid addresses");
    applyStimulus(1'b1, 32'h02, 1'b0, 1'b0, 32'h0,  32'h0,         fg, lg);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0,  32'h0,         fg, lg);
    applyStimulus(1'b0, 32'h0,  1'b1, 1'b1, 32'h84, 32'hFFFF_FFFF, fg, lg);
    applyStimulus(1'b0, 32'h0,  1'b1, 1'b0, 32'h04, 32'h0,         fg, lg);

    $display("[TB] starvation cap");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    lc    = 0;
    fSlot = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'(i % DEPTH) << 2, 1'b1, 1'b0, 32'((i + 5) % DEPTH) << 2, 32'h0, fg, lg);
      if (i < 9)  lc += int'(bus.l_gnt);
      if (i == 8) fSlot = int'(bus.f_gnt);
    end
    checkOutput("burst_loader_grants", 32'(lc),    32'd8);
    checkOutput("burst_fetch_slot",    32'(fSlot), 32'd1);

    $display("[TB] simultaneous first request");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 32'h18, 32'h0, fg, lg);
    firstL = bus.l_gnt;
    checkOutput("idle_tie_loader_first", 32'(firstL), 32'h1);
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 32'h1C, 32'h0, fg, lg);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  32'h0, fg, lg);
    checkOutput("fetch_after_loader_drops", 32'(bus.f_gnt), 32'h1);

    $display("[TB] reset mid-read");
    applyStimulus(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    repeat (2) begin
      applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h14, 32'h0, fg, lg);
      checkAllZero();
    end
    releaseReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    checkAllZero();

    $display("[TB] randomized traffic");
    fPend = 1'b0;
    lPend = 1'b0;
    fa    = '0;
    la    = '0;
    lw    = 1'b0;
    lwd   = '0;
    for (int i = 0; i < 400; i++) begin
      if (!fPend && $urandom_range(0, 99) < 60) begin
        fPend = 1'b1;
        fa    = randAddr();
      end
      if (!lPend && $urandom_range(0, 99) < 45) begin
        lPend = 1'b1;
        la    = randAddr();
        lw    = 1'($urandom_range(0, 1));
        lwd   = $urandom;
      end
      applyStimulus(fPend, fa, lPend, lw, la, lwd, fg, lg);
      if (fg) fPend = 1'b0;
      if (lg) lPend = 1'b0;
    end

    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, fg, lg);
    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
